// File: rtl/packet_assembler_pkg.sv
// Shared constants and types for the ejection-port packet assembler.
// Flit types are encoded in flit bits [1:0].
package packet_assembler_pkg;
    localparam int FLIT_WIDTH        = 16;
    localparam int MAX_PACKET_LENGHT = 5;

    localparam logic [1:0] FLIT_HEAD     = 2'b00;
    localparam logic [1:0] FLIT_BODY     = 2'b01;
    localparam logic [1:0] FLIT_TAIL     = 2'b10;
    localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL} buf_state_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ASSEMBLE, ST_DISCARD} asm_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/packet_assembler_if.sv
// Router ejection side and message_queue side of the packet assembler.
// The slave modport is the assembler; master is the surrounding fabric.
interface packet_assembler_if;
    import packet_assembler_pkg::*;

    logic [FLIT_WIDTH-1:0]                   in_flit_i;
    logic                                    in_valid_i;
    logic                                    in_ready_o;
    logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o;
    logic [MAX_PACKET_LENGHT-1:0]            out_sel_o;
    logic                                    r_pkt_to_msg_o;
    logic                                    g_pkt_to_msg_i;
    logic                                    error_o;

    modport slave (
        input  in_flit_i, in_valid_i, g_pkt_to_msg_i,
        output in_ready_o, out_link_o, out_sel_o, r_pkt_to_msg_o, error_o
    );
    modport master (
        output in_flit_i, in_valid_i, g_pkt_to_msg_i,
        input  in_ready_o, out_link_o, out_sel_o, r_pkt_to_msg_o, error_o
    );
endinterface

// File: rtl/packet_assembler_buffer.sv
// One packet buffer: flit slots, valid mask, fill count and EMPTY/FILLING/FULL state.
// A first-flit write restarts the packet, discarding any partial content.
module packet_buffer
    import packet_assembler_pkg::*;
#(
    parameter int N_BITS_FLIT_COUNT = clog2(MAX_PACKET_LENGHT)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_wr,
    input  logic                                    i_first,
    input  logic                                    i_set_full,
    input  logic                                    i_clear,
    input  logic                                    i_read,
    input  logic [FLIT_WIDTH-1:0]                   i_flit,
    output buf_state_t                              o_state,
    output logic [N_BITS_FLIT_COUNT-1:0]            o_count,
    output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] o_data,
    output logic [MAX_PACKET_LENGHT-1:0]            o_sel
);
    buf_state_t                              r_state;
    logic [N_BITS_FLIT_COUNT-1:0]            r_count;
    logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] r_data;
    logic [MAX_PACKET_LENGHT-1:0]            r_sel;

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_read) begin
            r_state <= BUF_EMPTY;
            r_count <= '0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (i_wr) begin
            if (i_first) begin
                r_data                 <= '0;
                r_data[FLIT_WIDTH-1:0] <= i_flit;
                r_sel                  <= '0;
                r_sel[0]               <= 1'b1;
                r_count                <= N_BITS_FLIT_COUNT'(1);
            end else begin
                for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
                    if (r_count == N_BITS_FLIT_COUNT'(k)) begin
                        r_data[k*FLIT_WIDTH +: FLIT_WIDTH] <= i_flit;
                        r_sel[k]                           <= 1'b1;
                    end
                end
                r_count <= r_count + 1'b1;
            end
            r_state <= i_set_full ? BUF_FULL : BUF_FILLING;
        end
    end

    assign o_state = r_state;
    assign o_count = r_count;
    assign o_data  = r_data;
    assign o_sel   = r_sel;
endmodule

// File: rtl/packet_assembler.sv
// Packs router flits into whole packets for message_queue using two ping-pong
// buffers; malformed sequences are dropped with a registered error pulse.
module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int N_BITS_FLIT_COUNT = clog2(MAX_PACKET_LENGHT)
) (
    input  logic               clk,
    input  logic               rst,
    packet_assembler_if.slave  bus
);
    localparam int LW = MAX_PACKET_LENGHT * FLIT_WIDTH;

    asm_state_t r_state;
    logic       r_wp, r_rp, r_error;

    buf_state_t                   w_bstate [2];
    logic [N_BITS_FLIT_COUNT-1:0] w_count  [2];
    logic [LW-1:0]                w_data   [2];
    logic [MAX_PACKET_LENGHT-1:0] w_sel    [2];

    asm_state_t w_nxt;
    logic [1:0] w_type;
    logic w_ready, w_acc, w_req, w_grant, w_is_head;
    logic w_wr, w_first, w_full, w_abort, w_err, w_tog;

    assign w_type    = bus.in_flit_i[1:0];
    assign w_is_head = (w_type == FLIT_HEAD) || (w_type == FLIT_HEADTAIL);
    // DISCARD always sinks flits: the aborted buffer[wp] is EMPTY there anyway.
    assign w_ready   = !rst && (r_state == ST_DISCARD || w_bstate[r_wp] != BUF_FULL);
    assign w_acc     = bus.in_valid_i && w_ready;
    assign w_req     = (w_bstate[r_rp] == BUF_FULL);
    assign w_grant   = w_req && bus.g_pkt_to_msg_i;

    always_comb begin
        w_wr    = 1'b0;
        w_first = 1'b0;
        w_full  = 1'b0;
        w_abort = 1'b0;
        w_err   = 1'b0;
        w_tog   = 1'b0;
        w_nxt   = r_state;
        if (w_acc) begin
            if (w_is_head) begin
                // A head always restarts buffer[wp]; mid-packet it also flags the loss.
                w_wr    = 1'b1;
                w_first = 1'b1;
                w_full  = (w_type == FLIT_HEADTAIL);
                w_tog   = w_full;
                w_err   = (r_state == ST_ASSEMBLE);
                w_nxt   = w_full ? ST_IDLE : ST_ASSEMBLE;
            end else begin
                case (r_state)
                    ST_IDLE: w_err = 1'b1;
                    ST_ASSEMBLE: begin
                        if (w_count[r_wp] == N_BITS_FLIT_COUNT'(MAX_PACKET_LENGHT)) begin
                            w_abort = 1'b1;
                            w_err   = 1'b1;
                            w_nxt   = (w_type == FLIT_TAIL) ? ST_IDLE : ST_DISCARD;
                        end else begin
                            w_wr = 1'b1;
                            if (w_type == FLIT_TAIL) begin
                                w_full = 1'b1;
                                w_tog  = 1'b1;
                                w_nxt  = ST_IDLE;
                            end
                        end
                    end
                    default: if (w_type == FLIT_TAIL) w_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_error <= w_err;
            if (w_tog)   r_wp <= ~r_wp;
            if (w_grant) r_rp <= ~r_rp;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        packet_buffer #(.N_BITS_FLIT_COUNT(N_BITS_FLIT_COUNT)) u_buf (
            .clk        (clk),
            .rst        (rst),
            .i_wr       (w_wr    && (r_wp == 1'(g))),
            .i_first    (w_first),
            .i_set_full (w_full),
            .i_clear    (w_abort && (r_wp == 1'(g))),
            .i_read     (w_grant && (r_rp == 1'(g))),
            .i_flit     (bus.in_flit_i),
            .o_state    (w_bstate[g]),
            .o_count    (w_count[g]),
            .o_data     (w_data[g]),
            .o_sel      (w_sel[g])
        );
    end

    assign bus.in_ready_o     = w_ready;
    assign bus.r_pkt_to_msg_o = w_req;
    assign bus.out_link_o     = w_data[r_rp];
    assign bus.out_sel_o      = w_sel[r_rp];
    assign bus.error_o        = r_error;
endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: directed scenarios plus random flit streams,
// checked against a queue-based packet model.
module tb_packet_assembler;
    import packet_assembler_pkg::*;

    localparam int FW = FLIT_WIDTH;
    localparam int ML = MAX_PACKET_LENGHT;
    localparam int LW = FW * ML;
    typedef logic [FW-1:0] flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    packet_assembler_if bus();
    packet_assembler dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: flits of the packet in progress, mode 0 idle / 1 assembling / 2 discarding,
    // and the queue of packets expected on the output side.
    flit_t         m_cur[$];
    int            m_mode;
    logic [LW-1:0] q_link[$];
    logic [ML-1:0] q_sel[$];

    function automatic void m_reset();
        m_cur.delete();
        m_mode = 0;
        q_link.delete();
        q_sel.delete();
    endfunction

    function automatic void m_finish();
        logic [LW-1:0] l;
        logic [ML-1:0] s;
        l = '0;
        s = '0;
        foreach (m_cur[k]) begin
            l[k*FW +: FW] = m_cur[k];
            s[k] = 1'b1;
        end
        q_link.push_back(l);
        q_sel.push_back(s);
        m_cur.delete();
        m_mode = 0;
    endfunction

    function automatic bit model_flit(input flit_t f);
        logic [1:0] t;
        bit e;
        t = f[1:0];
        e = 1'b0;
        if (t == 2'b00 || t == 2'b11) begin
            e = (m_mode == 1);
            m_cur.delete();
            m_cur.push_back(f);
            if (t == 2'b11) m_finish(); else m_mode = 1;
        end else if (m_mode == 0) begin
            e = 1'b1;
        end else if (m_mode == 2) begin
            if (t == 2'b10) m_mode = 0;
        end else if (m_cur.size() == ML) begin
            e = 1'b1;
            m_cur.delete();
            m_mode = (t == 2'b10) ? 0 : 2;
        end else begin
            m_cur.push_back(f);
            if (t == 2'b10) m_finish();
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_flit(input flit_t f, output bit obs_err, output bit exp_err);
        int t;
        t = 0;
        obs_err = 1'b0;
        exp_err = 1'b0;
        bus.in_flit_i  = f;
        bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout flit=%h ready=%b required=1", f, bus.in_ready_o);
            bus.in_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        obs_err = bus.error_o;
        bus.in_valid_i = 1'b0;
        exp_err = model_flit(f);
    endtask

    task automatic do_grant(output bit req, output logic [LW-1:0] l, output logic [ML-1:0] s);
        req = bus.r_pkt_to_msg_o;
        l   = bus.out_link_o;
        s   = bus.out_sel_o;
        bus.g_pkt_to_msg_i = 1'b1;
        @(negedge clk);
        bus.g_pkt_to_msg_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_flit_i = '0;
        bus.g_pkt_to_msg_i = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", bus.in_ready_o); end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.r_pkt_to_msg_o); end
        n_tests++; if (bus.out_link_o !== '0) begin n_fail++; $display("FAIL rst_link got %h exp 0", bus.out_link_o); end
        n_tests++; if (bus.out_sel_o !== '0) begin n_fail++; $display("FAIL rst_sel got %b exp 0", bus.out_sel_o); end
        n_tests++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.error_o); end
        rst = 1'b0;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_single();
        bit oe, ee, req;
        logic [LW-1:0] l, el;
        logic [ML-1:0] s, es;
        send_flit(16'h0003, oe, ee);
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b1) begin n_fail++; $display("FAIL single_req got %b exp 1", bus.r_pkt_to_msg_o); end
        n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL single_err got %b exp 0", oe); end
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (l !== 80'h3 || l !== el) begin n_fail++; $display("FAIL single_link got %h exp %h", l, el); end
        n_tests++; if (s !== 5'b00001 || s !== es) begin n_fail++; $display("FAIL single_sel got %b exp %b", s, es); end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0 || bus.out_link_o !== '0 || bus.out_sel_o !== '0)
            begin n_fail++; $display("FAIL single_after_grant got req=%b link=%h sel=%b exp 0", bus.r_pkt_to_msg_o, bus.out_link_o, bus.out_sel_o); end
    endtask

    task automatic test_full_packet();
        flit_t fl[5] = '{16'h0000, 16'hBBB1, 16'hBBB1, 16'hBBB1, 16'hFFF2};
        bit oe, ee, req;
        int errs;
        logic [LW-1:0] l, el;
        logic [ML-1:0] s, es;
        errs = 0;
        foreach (fl[i]) begin
            send_flit(fl[i], oe, ee);
            errs += int'(oe);
        end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL full_err got %0d exp 0", errs); end
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL full_req got %b exp 1", req); end
        n_tests++; if (l !== 80'hFFF2BBB1BBB1BBB10000 || l !== el) begin n_fail++; $display("FAIL full_link got %h exp %h", l, el); end
        n_tests++; if (s !== 5'b11111 || s !== es) begin n_fail++; $display("FAIL full_sel got %b exp %b", s, es); end
    endtask

    task automatic test_backpressure();
        bit oe, ee, req;
        logic [LW-1:0] l, el;
        logic [ML-1:0] s, es;
        send_flit(16'h0007, oe, ee);
        send_flit(16'h000B, oe, ee);
        bus.in_flit_i  = 16'h000F;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b exp 0", bus.in_ready_o); end
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (l !== 80'h7 || l !== el) begin n_fail++; $display("FAIL bp_order1 got %h exp %h", l, el); end
        n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_grant got %b exp 1", bus.in_ready_o); end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        void'(model_flit(16'h000F));
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (l !== 80'hB || l !== el) begin n_fail++; $display("FAIL bp_order2 got %h exp %h", l, el); end
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (req !== 1'b1 || l !== 80'hF || l !== el) begin n_fail++; $display("FAIL bp_order3 got req=%b %h exp %h", req, l, el); end
    endtask

    task automatic test_simultaneous();
        bit oe, ee;
        logic [LW-1:0] l0;
        send_flit(16'h0007, oe, ee);
        l0 = bus.out_link_o;
        bus.in_flit_i      = 16'h000B;
        bus.in_valid_i     = 1'b1;
        bus.g_pkt_to_msg_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i     = 1'b0;
        bus.g_pkt_to_msg_i = 1'b0;
        void'(model_flit(16'h000B));
        void'(q_link.pop_front());
        void'(q_sel.pop_front());
        n_tests++; if (l0 !== 80'h7) begin n_fail++; $display("FAIL simul_before got %h exp 7", l0); end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b1 || bus.out_link_o !== q_link[0])
            begin n_fail++; $display("FAIL simul_after got req=%b %h exp 1 %h", bus.r_pkt_to_msg_o, bus.out_link_o, q_link[0]); end
        bus.g_pkt_to_msg_i = 1'b1;
        @(negedge clk);
        bus.g_pkt_to_msg_i = 1'b0;
        void'(q_link.pop_front());
        void'(q_sel.pop_front());
    endtask

    task automatic test_orphan();
        bit oe, ee;
        send_flit(16'h0001, oe, ee);
        n_tests++; if (oe !== 1'b1 || oe !== ee) begin n_fail++; $display("FAIL orphan_err got %b exp 1", oe); end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0) begin n_fail++; $display("FAIL orphan_req got %b exp 0", bus.r_pkt_to_msg_o); end
        @(negedge clk);
        n_tests++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL orphan_pulse_len got %b exp 0", bus.error_o); end
    endtask

    task automatic test_malformed_ht();
        bit oe1, oe2, oe3, ee, req;
        logic [LW-1:0] l, el;
        logic [ML-1:0] s, es;
        send_flit(16'h0000, oe1, ee);
        send_flit(16'hBBB1, oe2, ee);
        send_flit(16'h0003, oe3, ee);
        n_tests++; if ({oe1, oe2, oe3} !== 3'b001) begin n_fail++; $display("FAIL mal_ht_err got %b exp 001", {oe1, oe2, oe3}); end
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (req !== 1'b1 || l !== 80'h3 || l !== el || s !== es)
            begin n_fail++; $display("FAIL mal_ht_pkt got req=%b %h %b exp 1 %h %b", req, l, s, el, es); end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0) begin n_fail++; $display("FAIL mal_ht_extra got %b exp 0", bus.r_pkt_to_msg_o); end
    endtask

    task automatic test_overflow();
        bit oe, ee, req;
        int errs;
        logic [LW-1:0] l;
        logic [ML-1:0] s;
        errs = 0;
        send_flit(16'h0000, oe, ee);
        errs += int'(oe);
        for (int i = 0; i < 6; i++) begin
            send_flit(16'hBBB1, oe, ee);
            errs += int'(oe);
        end
        send_flit(16'hFFF2, oe, ee);
        errs += int'(oe);
        n_tests++; if (errs != 1) begin n_fail++; $display("FAIL ovf_err got %0d exp 1", errs); end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0) begin n_fail++; $display("FAIL ovf_req got %b exp 0", bus.r_pkt_to_msg_o); end
        send_flit(16'h1233, oe, ee);
        do_grant(req, l, s);
        void'(q_sel.pop_front());
        n_tests++; if (oe !== 1'b0 || req !== 1'b1 || l !== q_link.pop_front())
            begin n_fail++; $display("FAIL ovf_idle got err=%b req=%b %h exp 0 1 1233", oe, req, l); end
    endtask

    task automatic test_reset_mid();
        flit_t fl[5] = '{16'h1230, 16'h4561, 16'h7891, 16'hABC1, 16'hDEF2};
        bit oe, ee, req;
        logic [LW-1:0] l, el;
        logic [ML-1:0] s, es;
        send_flit(16'h0000, oe, ee);
        send_flit(16'hBBB1, oe, ee);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0 || bus.out_link_o !== '0 || bus.out_sel_o !== '0 || bus.in_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_outputs got req=%b %h %b rdy=%b exp all 0", bus.r_pkt_to_msg_o, bus.out_link_o, bus.out_sel_o, bus.in_ready_o); end
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_noemit got %b exp 0", bus.r_pkt_to_msg_o); end
        foreach (fl[i]) send_flit(fl[i], oe, ee);
        do_grant(req, l, s);
        el = q_link.pop_front();
        es = q_sel.pop_front();
        n_tests++; if (req !== 1'b1 || l !== 80'hDEF2ABC1789145611230 || l !== el || s !== es)
            begin n_fail++; $display("FAIL rstmid_pkt got req=%b %h %b exp 1 %h %b", req, l, s, el, es); end
    endtask

    task automatic test_random();
        bit oe, ee, req;
        logic [LW-1:0] l, el;
        logic [ML-1:0] s, es;
        logic [1:0] t;
        int r;
        flit_t f;
        for (int i = 0; i < 400; i++) begin
            if (q_link.size() == 2 || (q_link.size() > 0 && $urandom_range(0, 2) == 0)) begin
                do_grant(req, l, s);
                el = q_link.pop_front();
                es = q_sel.pop_front();
                n_tests++; if (req !== 1'b1 || l !== el || s !== es)
                    begin n_fail++; $display("FAIL rand_pkt got req=%b %h %b exp 1 %h %b", req, l, s, el, es); end
            end else if (q_link.size() == 0 && $urandom_range(0, 7) == 0) begin
                do_grant(req, l, s);
                n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL rand_idle_req got %b exp 0", req); end
            end
            r = $urandom_range(0, 19);
            t = (r < 5) ? 2'b00 : (r < 13) ? 2'b01 : (r < 17) ? 2'b10 : 2'b11;
            f = {14'($urandom), t};
            send_flit(f, oe, ee);
            n_tests++; if (oe !== ee) begin n_fail++; $display("FAIL rand_err flit=%h got %b exp %b", f, oe, ee); end
        end
        while (q_link.size() > 0) begin
            do_grant(req, l, s);
            el = q_link.pop_front();
            es = q_sel.pop_front();
            n_tests++; if (req !== 1'b1 || l !== el || s !== es)
                begin n_fail++; $display("FAIL rand_drain got req=%b %h %b exp 1 %h %b", req, l, s, el, es); end
        end
        n_tests++; if (bus.r_pkt_to_msg_o !== 1'b0) begin n_fail++; $display("FAIL rand_end_req got %b exp 0", bus.r_pkt_to_msg_o); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_full_packet();
        test_backpressure();
        test_simultaneous();
        test_orphan();
        test_malformed_ht();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/packet_assembler.md
# packet_assembler

Collects flits arriving from the router's ejection port and packs them into whole packets for `message_queue`. It drives `message_queue`'s `in_link_i`, `in_sel_i` and `r_pkt_to_msg_i`, and consumes `g_pkt_to_msg_o`. Two packet buffers are used in ping-pong fashion, so a packet can be assembled while the previous one waits for its grant. Malformed flit sequences are dropped and flagged.

## Interface
- `N_BITS_FLIT_COUNT`, default `clog2(`MAX_PACKET_LENGHT)`: width of the per-buffer flit counter.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_flit_i`  in  `FLIT_WIDTH`  flit from router; bits [1:0] hold the flit type: 00 head, 01 body, 10 tail, 11 head-tail.
- `in_valid_i`  in  1  `in_flit_i` valid.
- `in_ready_o`  out  1  flit accepted on an edge where valid and ready are both high.
- `out_link_o`  out  `MAX_PACKET_LENGHT*FLIT_WIDTH`  packed packet; connects to `message_queue.in_link_i`.
- `out_sel_o`  out  `MAX_PACKET_LENGHT`  per-flit valid mask; connects to `in_sel_i`.
- `r_pkt_to_msg_o`  out  1  packet request; connects to `r_pkt_to_msg_i`.
- `g_pkt_to_msg_i`  in  1  grant from `message_queue`.
- `error_o`  out  1  one-cycle pulse when a malformed sequence is dropped.

## Operation
- **Buffers.** Two buffers, each with state EMPTY, FILLING or FULL.
  - Write pointer `wp` selects the buffer being filled.
  - Read pointer `rp` selects the buffer presented on the outputs.
  - Both pointers toggle 0→1→0, so delivery order equals arrival order.
- **Packing.** Flit k of a packet goes to `out_link_o[k*FLIT_WIDTH +: FLIT_WIDTH]` and sets `out_sel_o[k]`. Unused slots are all zero.
- **Assembler FSM** has three states: IDLE, ASSEMBLE, DISCARD.
  - IDLE + head: write slot 0, count=1, buffer[wp] becomes FILLING, go to ASSEMBLE.
  - IDLE + head-tail: write slot 0, buffer[wp] becomes FULL, toggle `wp`, stay IDLE.
  - IDLE + body/tail: drop the flit, pulse `error_o`, stay IDLE.
  - ASSEMBLE + body: write slot count, count+1.
  - ASSEMBLE + tail: write slot count, buffer becomes FULL, toggle `wp`, go to IDLE.
  - ASSEMBLE + head or head-tail: clear the current buffer to EMPTY, pulse `error_o`, then handle the new flit exactly as in IDLE.
  - ASSEMBLE + any body/tail when count == `MAX_PACKET_LENGHT`: clear the buffer to EMPTY, pulse `error_o`. A tail goes to IDLE; a body goes to DISCARD.
  - DISCARD: accept and drop every flit. A tail goes to IDLE. A head or head-tail is handled as in IDLE, with no further error pulse.
- **Output side.**
  - `r_pkt_to_msg_o` = buffer[rp] is FULL.
  - `out_link_o` and `out_sel_o` show buffer[rp] and stay stable while the request is high.
  - On an edge with `r_pkt_to_msg_o` && `g_pkt_to_msg_i`: buffer[rp] becomes EMPTY (data and sel cleared) and `rp` toggles.
  - A grant seen while the request is low is ignored.
- **Back-pressure.** `in_ready_o` = !rst && (state == DISCARD || buffer[wp] != FULL).

## Timing
- **Reset values.**
  - Outputs: `r_pkt_to_msg_o`=0, `out_link_o`=0, `out_sel_o`=0, `error_o`=0, `in_ready_o`=0 while `rst` is high.
  - Internal: `wp`=`rp`=0, both buffers EMPTY, FSM in IDLE.
- **Reset mid-packet.** Any partial or full packet is lost; nothing is emitted afterwards.
- **Request latency.** Tail or head-tail accepted at edge N → `r_pkt_to_msg_o` high from cycle N+1.
- **Grant.** Grant at edge M → the next buffer's request is visible from M+1 if that buffer is FULL. One packet per cycle is sustainable.
- **Simultaneous events.** Completing a write into buffer[wp] and granting buffer[rp] on the same edge are independent and both take effect.
- **Both buffers FULL.** `in_ready_o` is low and the flit is held upstream. It becomes high the cycle after a grant.
- **Error pulse.** `error_o` is high exactly one cycle after the offending edge. It is registered, so no combinational path from `in_flit_i`.

## Structure
- Flit-type encodings and `FLIT_WIDTH` / `MAX_PACKET_LENGHT` come from `NIC-defines.v`; add the type codes there as `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`, `FLIT_HEADTAIL`.
- `clog2` comes from `NIC_utils.vh`.
- Sub-module `packet_buffer` (instantiated ×2) holds data, sel, count and state. It takes write-flit, set-full, clear and read strobes.

## Test plan
- **Single flit.** 16'h0003 → `out_link_o`=80'h00000000000000000003, `out_sel_o`=5'b00001, request the next cycle. Grant → request drops, outputs zero.
- **Full packet.** Flits 0000, BBB1, BBB1, BBB1, FFF2 → `out_link_o`=80'hFFF2BBB1BBB1BBB10000, `out_sel_o`=5'b11111.
- **Back-pressure.** Grant held low, three single-flit packets → two buffered, `in_ready_o` low on the third. One grant → third accepted. Delivery order is 1, 2, 3.
- **Orphan flit.** Body flit 0001 while IDLE → `error_o` one pulse, no request.
- **Malformed packets.**
  - Head, body, then head-tail 0003 → error pulse; only 80'h…0003 with sel 00001 is delivered.
  - Head plus six bodies plus tail → error pulse, nothing delivered, FSM back in IDLE.
- **Reset mid-packet.** `rst` after two flits of a packet → all outputs zero. A following 5-flit packet is delivered intact.
